// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants and the pc/instr entry used by IF/ID and ID/EX registers.
package pipe_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } pipe_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x 64 entry storage, one write port, one asynchronous read port, no reset.
module fetch_queue_mem
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  pipe_entry_t   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output pipe_entry_t   o_rdata
);
    pipe_entry_t r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer between fetch and decode; stalls fetch when full,
// flushes wrong-path entries on redirect.
module fetch_queue
    import pipe_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter int          AW    = 2,
    parameter logic [31:0] NOP   = NOP_INSTR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          fetch_stop,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_pc8,
    input  logic          id_stall,
    input  logic          flush,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push, w_pop, w_full;
    pipe_entry_t   w_head;
    assign w_full     = r_count == FULL;
    assign out_valid  = r_count != '0;
    assign w_pop      = out_valid && !id_stall;
    assign w_push     = in_valid && !flush && (!w_full || w_pop);
    assign fetch_stop = w_full && !w_pop && !flush;
    assign count      = r_count;
    assign out_pc     = out_valid ? w_head.pc : 32'h0;
    assign out_instr  = out_valid ? w_head.instr : NOP;
    assign out_pc8    = out_valid ? w_head.pc + 32'd8 : 32'h0;
    fetch_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ('{pc: in_pc, instr: in_instr}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );
    // A flush drops everything buffered; the head popped in the same cycle was already taken by decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard of expected PCs checked by a pop monitor.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        id_stall = 1'b0;
    logic        flush = 1'b0;
    logic        fetch_stop, out_valid;
    logic [31:0] out_pc, out_instr, out_pc8;
    logic [2:0]  count;
    int          total = 0;
    int          bad = 0;
    logic [31:0] sb [$];
    logic [31:0] mon_e;
    logic        last_stop;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .fetch_stop (fetch_stop),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .out_pc8    (out_pc8),
        .id_stall   (id_stall),
        .flush      (flush),
        .count      (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode takes the head at the coming edge whenever out_valid && !id_stall.
    always @(negedge clk) begin
        if (reset) sb.delete();
        else begin
            if (out_valid && !id_stall) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop got=%h want=none", out_pc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pop_pc", out_pc, mon_e);
                    chk("pop_instr", out_instr, ~mon_e);
                    chk("pop_pc8", out_pc8, mon_e + 32'd8);
                end
            end
            if (flush) sb.delete();
        end
    end

    task automatic cyc(input logic v, input logic [31:0] pc, input logic st, input logic fl, input logic acc);
        in_valid = v;
        in_pc    = pc;
        in_instr = ~pc;
        id_stall = st;
        flush    = fl;
        if (acc) sb.push_back(pc);
        #1 last_stop = fetch_stop;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc8", out_pc8, 32'h0);
        chk("rst_stop", 32'(fetch_stop), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        // Reset mid-stream acts before the next edge.
        cyc(1, 32'h3000, 1, 0, 1);
        cyc(1, 32'h3004, 1, 0, 1);
        chk("mid_count_pre", 32'(count), 32'd2);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_instr", out_instr, 32'h0);
        #5 reset = 1'b0;
        @(posedge clk);
        #1;
        // Fill while decode is stalled.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'h3000 + 32'(4 * i), 1, 0, 1);
            chk("fill_stop", 32'(last_stop), 32'd0);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_head", out_pc, 32'h3000);
        end
        cyc(1, 32'h3010, 1, 0, 0);
        chk("full_stop", 32'(last_stop), 32'd1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_head", out_pc, 32'h3000);
        // Full with a simultaneous pop accepts the push.
        cyc(1, 32'h3010, 0, 0, 1);
        chk("fullpop_stop", 32'(last_stop), 32'd0);
        chk("fullpop_count", 32'(count), 32'd4);
        for (int i = 3; i >= 0; i--) begin
            cyc(0, 32'h0, 0, 0, 0);
            chk("drain_count", 32'(count), 32'(i));
        end
        // Streaming: one cycle latency, count holds at 1.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'h5000 + 32'(4 * i), 0, 0, 1);
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_pc", out_pc, 32'h5000 + 32'(4 * i));
            chk("stream_pc8", out_pc8, 32'h5008 + 32'(4 * i));
        end
        cyc(0, 32'h0, 0, 0, 0);
        chk("stream_end", 32'(count), 32'd0);
        // Flush drops buffered entries and the same-cycle push.
        cyc(1, 32'h3004, 1, 0, 1);
        cyc(1, 32'h3008, 1, 0, 1);
        cyc(1, 32'h300C, 1, 1, 0);
        chk("flush_stop", 32'(last_stop), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        cyc(1, 32'h4000, 1, 0, 1);
        chk("post_flush_pc", out_pc, 32'h4000);
        chk("post_flush_count", 32'(count), 32'd1);
        cyc(1, 32'h4004, 1, 0, 1);
        cyc(0, 32'h0, 0, 1, 0);
        chk("flushpop_count", 32'(count), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1, 32'h7000 + 32'(4 * i), 1, 0, 1);
        cyc(1, 32'h7010, 1, 1, 0);
        chk("flushfull_stop", 32'(last_stop), 32'd0);
        chk("flushfull_count", 32'(count), 32'd0);
        // Ten push/pop pairs through the wrapping pointers.
        for (int i = 0; i < 10; i++) begin
            cyc(1, 32'h6000 + 32'(4 * i), 0, 0, 1);
            chk("wrap_count", 32'(count), 32'd1);
        end
        cyc(0, 32'h0, 0, 0, 0);
        chk("wrap_end", 32'(count), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
